audio_dac_serializer: RTL and testbench



---
 rtl/audio_dac_serializer_if.sv | 27 ++
 rtl/audio_dac_serializer.sv | 77 +++++++
 tb/tb_audio_dac_serializer.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/audio_dac_serializer_if.sv
// rtl/audio_dac_serializer_if.sv - frame clock, stereo samples and serial outputs of the I2S DAC serializer
interface audio_dac_serializer_if;
    logic        AUD_DACLRCK;
    logic [31:0] left_channel_audio_in;
    logic [31:0] right_channel_audio_in;
    logic        AUD_DACDAT;
    logic        sample_strobe;
    logic        short_slot;

    modport master (
        output AUD_DACLRCK,
        output left_channel_audio_in,
        output right_channel_audio_in,
        input  AUD_DACDAT,
        input  sample_strobe,
        input  short_slot
    );

    modport slave (
        input  AUD_DACLRCK,
        input  left_channel_audio_in,
        input  right_channel_audio_in,
        output AUD_DACDAT,
        output sample_strobe,
        output short_slot
    );
endinterface

// File: rtl/audio_dac_serializer.sv
// rtl/audio_dac_serializer.sv - I2S serializer of a stereo sample pair onto the codec DAC data line
module audio_dac_serializer #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  AUD_BCLK,
    input  logic                  reset,
    audio_dac_serializer_if.slave bus
);
    localparam logic [5:0] FULL = 6'(DATA_WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        LEFT,
        RIGHT
    } state_t;

    state_t      state;
    logic        lrck_d;
    logic [31:0] hold_r;
    logic [31:0] shift;
    logic [5:0]  bit_cnt;
    logic        dat_q;
    logic        strobe_q;
    logic        short_q;
    logic        fall;
    logic        rise;

    assign fall = !bus.AUD_DACLRCK && lrck_d;
    assign rise = bus.AUD_DACLRCK && !lrck_d;

    assign bus.AUD_DACDAT    = dat_q;
    assign bus.sample_strobe = strobe_q;
    assign bus.short_slot    = short_q;

    always_ff @(posedge AUD_BCLK or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            lrck_d   <= 1'b0;
            hold_r   <= '0;
            shift    <= '0;
            bit_cnt  <= FULL;
            dat_q    <= 1'b0;
            strobe_q <= 1'b0;
            short_q  <= 1'b0;
        end else begin
            lrck_d   <= bus.AUD_DACLRCK;
            strobe_q <= 1'b0;
            short_q  <= 1'b0;
            if (fall) begin
                // Capture both channels together so the right slot never mixes frames.
                hold_r   <= bus.right_channel_audio_in;
                dat_q    <= bus.left_channel_audio_in[31];
                shift    <= {bus.left_channel_audio_in[30:0], 1'b0};
                bit_cnt  <= 6'd1;
                strobe_q <= 1'b1;
                short_q  <= (state != IDLE) && (bit_cnt < FULL);
                state    <= LEFT;
            end else if (rise && state == LEFT) begin
                dat_q    <= hold_r[31];
                shift    <= {hold_r[30:0], 1'b0};
                bit_cnt  <= 6'd1;
                short_q  <= (bit_cnt < FULL);
                state    <= RIGHT;
            end else if (state == IDLE) begin
                // Rising edges are ignored here so start-up never begins on the right channel.
                dat_q    <= 1'b0;
                bit_cnt  <= FULL;
            end else if (bit_cnt < FULL) begin
                dat_q    <= shift[31];
                shift    <= {shift[30:0], 1'b0};
                bit_cnt  <= bit_cnt + 6'd1;
            end else begin
                dat_q    <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_audio_dac_serializer.sv
// tb/tb_audio_dac_serializer.sv - directed bench with a slot-level reference model of the I2S serializer
module tb_audio_dac_serializer;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    audio_dac_serializer_if bus ();

    audio_dac_serializer #(.DATA_WIDTH(DW)) dut (
        .AUD_BCLK (clk),
        .reset    (rst),
        .bus      (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    int          strobe_cnt = 0;
    int          short_cnt  = 0;
    logic [127:0] cap = '0;

    logic        m_prev    = 1'b0;
    logic        m_started = 1'b0;
    logic        m_in_left = 1'b0;
    logic [31:0] m_word    = '0;
    logic [31:0] m_hold_r  = '0;
    int          m_idx     = DW;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Each negedge evaluates the posedge just gone: slot boundaries come from the
    // LRCK level seen there, and the output bit is the word's bit at its slot position.
    initial begin : compare
        logic l, fall, rise, e_dat, e_strobe, e_short;
        forever begin
            @(negedge clk);
            e_dat = 1'b0; e_strobe = 1'b0; e_short = 1'b0;
            if (rst) begin
                m_prev = 1'b0; m_started = 1'b0; m_in_left = 1'b0; m_idx = DW;
            end else begin
                l    = bus.AUD_DACLRCK;
                fall = !l && m_prev;
                rise = l && !m_prev;
                if (fall) begin
                    e_short   = m_started && (m_idx < DW);
                    e_strobe  = 1'b1;
                    m_word    = bus.left_channel_audio_in;
                    m_hold_r  = bus.right_channel_audio_in;
                    m_idx     = 0;
                    m_started = 1'b1;
                    m_in_left = 1'b1;
                end else if (rise && m_started && m_in_left) begin
                    e_short   = (m_idx < DW);
                    m_word    = m_hold_r;
                    m_idx     = 0;
                    m_in_left = 1'b0;
                end
                if (m_started && m_idx < DW) begin
                    e_dat = m_word[31-m_idx];
                    m_idx++;
                end
                m_prev = l;
            end
            check("dacdat", 128'(bus.AUD_DACDAT), 128'(e_dat));
            check("sample_strobe", 128'(bus.sample_strobe), 128'(e_strobe));
            check("short_slot", 128'(bus.short_slot), 128'(e_short));
            cap = {cap[126:0], bus.AUD_DACDAT};
            if (bus.sample_strobe) strobe_cnt++;
            if (bus.short_slot) short_cnt++;
        end
    end

    task automatic drive_lrck(input logic l);
        @(negedge clk);
        #2;
        bus.AUD_DACLRCK = l;
    endtask

    task automatic run_frames(input int n, input int slot, input logic [31:0] lv, input logic [31:0] rv);
        bus.left_channel_audio_in  = lv;
        bus.right_channel_audio_in = rv;
        for (int f = 0; f < n; f++) begin
            for (int i = 0; i < 2 * slot; i++) drive_lrck(i >= slot);
        end
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    int s0, k0;

    initial begin : stim
        rst = 1'b1;
        bus.AUD_DACLRCK = 1'b0;
        bus.left_channel_audio_in  = '0;
        bus.right_channel_audio_in = '0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_dacdat", 128'(bus.AUD_DACDAT), 128'(0));
        check("reset_strobe", 128'(bus.sample_strobe), 128'(0));
        check("reset_short", 128'(bus.short_slot), 128'(0));
        #1 rst = 1'b0;

        // No falling LRCK yet in the first frame: silent, no strobe.
        s0 = strobe_cnt; k0 = short_cnt;
        run_frames(1, 32, 32'hA5A5_0F0F, 32'h1234_5678);
        settle();
        check("first_frame_silent", cap[63:0], 128'(0));
        check("first_frame_strobes", 128'(strobe_cnt - s0), 128'(0));
        run_frames(3, 32, 32'hA5A5_0F0F, 32'h1234_5678);
        settle();
        check("three_frame_strobes", 128'(strobe_cnt - s0), 128'(3));

        run_frames(1, 32, 32'h8000_0001, 32'h7FFF_FFFF);
        settle();
        check("frame_32_bits", cap[63:0], {64'h0, 32'h8000_0001, 32'h7FFF_FFFF});
        check("no_short_32", 128'(short_cnt - k0), 128'(0));

        run_frames(1, 48, 32'hFFFF_FFFF, 32'h0000_0001);
        settle();
        check("frame_48_bits", cap[95:0], {32'h0, 32'hFFFF_FFFF, 16'h0, 32'h0000_0001, 16'h0});
        check("no_short_48", 128'(short_cnt - k0), 128'(0));

        k0 = short_cnt;
        run_frames(2, 24, 32'hDEAD_BEEF, 32'h0BAD_F00D);
        settle();
        check("frame_24_bits", cap[47:0], {80'h0, 24'hDEAD_BE, 24'h0BAD_F0});
        check("short_24_count", 128'(short_cnt - k0), 128'(3));

        // Start-up with LRCK high: the rise seen after reset must not start a slot.
        bus.AUD_DACLRCK = 1'b1;
        #1 rst = 1'b1;
        repeat (3) drive_lrck(1'b1);
        rst = 1'b0;
        s0 = strobe_cnt; k0 = short_cnt;
        repeat (9) drive_lrck(1'b1);
        settle();
        check("idle_high_silent", cap[9:0], 128'(0));
        check("idle_high_strobes", 128'(strobe_cnt - s0), 128'(0));
        run_frames(1, 32, 32'h0000_FFFF, 32'hFFFF_0000);
        settle();
        check("startup_frame_bits", cap[63:0], {64'h0, 32'h0000_FFFF, 32'hFFFF_0000});
        check("startup_strobes", 128'(strobe_cnt - s0), 128'(1));
        check("startup_short", 128'(short_cnt - k0), 128'(0));

        // Reset at bit 10 of the left slot, released three cycles later.
        s0 = strobe_cnt;
        bus.left_channel_audio_in  = 32'hFFFF_FFFF;
        bus.right_channel_audio_in = 32'hFFFF_FFFF;
        for (int i = 0; i < 64; i++) begin
            drive_lrck(i >= 32);
            if (i == 10) begin
                check("bit9_before_reset", 128'(bus.AUD_DACDAT), 128'(1));
                rst = 1'b1;
                #1;
                check("async_reset_dat", 128'(bus.AUD_DACDAT), 128'(0));
            end
            if (i == 13) rst = 1'b0;
        end
        settle();
        check("after_reset_silent", cap[53:0], 128'(0));
        check("reset_frame_strobes", 128'(strobe_cnt - s0), 128'(1));
        s0 = strobe_cnt; k0 = short_cnt;
        run_frames(1, 32, 32'h1357_9BDF, 32'h2468_ACE0);
        settle();
        check("resume_frame_bits", cap[63:0], {64'h0, 32'h1357_9BDF, 32'h2468_ACE0});
        check("resume_strobes", 128'(strobe_cnt - s0), 128'(1));
        check("resume_short", 128'(short_cnt - k0), 128'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not complete by %0t", $time);
        $fatal(1, "watchdog");
    end
endmodule
